// File: rtl/arbiter_rr_n.sv
// -----------------------------------------------------------------------------
// arbiter_rr_n
// N-channel round-robin arbiter. It merges NUM_CH slave beat streams into one
// registered master stream that feeds a downstream FIFO. A grant is held for a
// burst of up to MAX_BURST beats and stalls while the FIFO is full. The grant is
// released, and the round-robin pointer re-homed to 0, when the master signals
// completion.
//
// Optional build macro: ARB_MODE_FILTER_EN
//   Defined   : beats with the reserved all-ones mode are consumed but not
//               forwarded, and the sticky err_mode flag is set.
//   Undefined : reserved-mode beats are forwarded normally; err_mode is 0.
// -----------------------------------------------------------------------------
module arbiter_rr_n #(
  parameter int NUM_CH    = 4,
  parameter int DW        = 32,
  parameter int MW        = 2,
  parameter int PVW       = 8,
  parameter int MAX_BURST = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      fifo_full,
  input  logic                      mstr0_cmplt,
  input  logic [NUM_CH-1:0]         slv_data_valid,
  input  logic [NUM_CH*MW-1:0]      slv_mode,
  input  logic [NUM_CH*PVW-1:0]     slv_proc_valid,
  input  logic [NUM_CH*DW-1:0]      slv_data,
  output logic [NUM_CH-1:0]         slv_ready,
  output logic                      slvx_data_valid,
  output logic [MW-1:0]             slvx_mode,
  output logic [PVW-1:0]            slvx_proc_val,
  output logic [DW-1:0]             slvx_data,
  output logic [$clog2(NUM_CH)-1:0] slvx_grant_id,
  output logic                      err_mode
);

  localparam int             IDW         = $clog2(NUM_CH);
  localparam logic [7:0]     MAX_BURST_C = 8'(MAX_BURST);
  localparam logic [IDW:0]   NUM_CH_C    = (IDW+1)'(NUM_CH);
  localparam logic [IDW-1:0] LAST_CH     = IDW'(NUM_CH - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDW-1:0]   r_grant;
  logic [IDW-1:0]   w_grant_nxt;
  logic [IDW-1:0]   r_rr_ptr;
  logic [IDW-1:0]   w_rr_nxt;
  logic [7:0]       r_burst_cnt;
  logic [7:0]       w_cnt_nxt;
  logic [7:0]       w_cnt_inc;
  logic [IDW-1:0]   w_grant_inc;
  logic [IDW-1:0]   w_arb_pick;
  logic             w_arb_found;
  logic             w_gvalid;
  logic             w_accept;
  logic             w_reserved;
  logic [MW-1:0]    w_sel_mode;
  logic [PVW-1:0]   w_sel_pv;
  logic [DW-1:0]    w_sel_data;

  logic             r_out_valid;
  logic [MW-1:0]    r_out_mode;
  logic [PVW-1:0]   r_out_pv;
  logic [DW-1:0]    r_out_data;
  logic [IDW-1:0]   r_out_gid;

  assign w_gvalid    = slv_data_valid[r_grant];
  assign w_cnt_inc   = r_burst_cnt + 8'd1;
  assign w_grant_inc = (r_grant == LAST_CH) ? '0 : r_grant + IDW'(1);

  // Round-robin scan: first valid channel starting at r_rr_ptr, wrapping at NUM_CH.
  always_comb begin : p_arb
    logic [IDW:0]   sum;
    logic [IDW-1:0] idx;
    // NOTE: every variable gets a default before any branch, so no path can infer a latch.
    w_arb_found = 1'b0;
    w_arb_pick  = '0;
    sum         = '0;
    idx         = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      sum = {1'b0, r_rr_ptr} + (IDW+1)'(k);
      if (sum >= NUM_CH_C) sum = sum - NUM_CH_C;
      idx = sum[IDW-1:0];
      if (!w_arb_found && slv_data_valid[idx]) begin
        w_arb_found = 1'b1;
        w_arb_pick  = idx;
      end
    end
  end

  // Route the granted channel's beat fields onto the internal select bus.
  always_comb begin
    w_sel_mode = '0;
    w_sel_pv   = '0;
    w_sel_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (r_grant == IDW'(i)) begin
        w_sel_mode = slv_mode[i*MW +: MW];
        w_sel_pv   = slv_proc_valid[i*PVW +: PVW];
        w_sel_data = slv_data[i*DW +: DW];
      end
    end
  end

`ifdef ARB_MODE_FILTER_EN
  assign w_reserved = (w_sel_mode == {MW{1'b1}});
`else
  assign w_reserved = 1'b0;
`endif

  // Next-state, pointer, burst count and ready; completion outranks every other exit.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_rr_nxt    = r_rr_ptr;
    w_cnt_nxt   = r_burst_cnt;
    w_accept    = 1'b0;
    slv_ready   = '0;
    case (r_state)
      IDLE: begin
        if (mstr0_cmplt) begin
          w_rr_nxt = '0;
        end else if (w_arb_found) begin
          w_grant_nxt = w_arb_pick;
          w_state_nxt = GRANT;
        end
      end
      GRANT: begin
        slv_ready[r_grant] = ~fifo_full & ~mstr0_cmplt;
        w_accept           = w_gvalid & ~fifo_full & ~mstr0_cmplt;
        if (mstr0_cmplt) begin
          w_state_nxt = IDLE;
          w_rr_nxt    = '0;
          w_cnt_nxt   = '0;
        end else if ((w_accept && (w_cnt_inc == MAX_BURST_C)) ||
                     (!w_gvalid && !fifo_full)) begin
          w_state_nxt = IDLE;
          w_rr_nxt    = w_grant_inc;
          w_cnt_nxt   = '0;
        end else if (w_accept) begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Arbitration state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_grant     <= '0;
      r_rr_ptr    <= '0;
      r_burst_cnt <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_state     <= w_state_nxt;
      r_grant     <= w_grant_nxt;
      r_rr_ptr    <= w_rr_nxt;
      r_burst_cnt <= w_cnt_nxt;
    end
  end

  // Output stage: strobe every cycle, fields only reload on a forwarded beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_mode  <= '0;
      r_out_pv    <= '0;
      r_out_data  <= '0;
      r_out_gid   <= '0;
    end else begin
      r_out_valid <= w_accept & ~w_reserved;
      if (w_accept && !w_reserved) begin
        r_out_mode <= w_sel_mode;
        r_out_pv   <= w_sel_pv;
        r_out_data <= w_sel_data;
        r_out_gid  <= r_grant;
      end
    end
  end

`ifdef ARB_MODE_FILTER_EN
  logic r_err_mode;

  // Sticky flag: set by any consumed reserved-mode beat, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_mode <= 1'b0;
    end else if (w_accept && w_reserved) begin
      r_err_mode <= 1'b1;
    end
  end

  assign err_mode = r_err_mode;
`else
  assign err_mode = 1'b0;
`endif

  assign slvx_data_valid = r_out_valid;
  assign slvx_mode       = r_out_mode;
  assign slvx_proc_val   = r_out_pv;
  assign slvx_data       = r_out_data;
  assign slvx_grant_id   = r_out_gid;

endmodule

// File: tb/tb_arbiter_rr_n.sv
// -----------------------------------------------------------------------------
// tb_arbiter_rr_n
// Randomized and directed bench for arbiter_rr_n. Each slave owns a list of
// beats it wants to send. A cycle-level reference model holds the owner, the
// pointer and the beat count as plain integers and predicts ready and the
// registered output stream. Build with ARB_MODE_FILTER_EN to check the filter.
// -----------------------------------------------------------------------------
module tb_arbiter_rr_n;

  localparam int NUM_CH    = 4;
  localparam int DW        = 32;
  localparam int MW        = 2;
  localparam int PVW       = 8;
  localparam int MAX_BURST = 16;
  localparam int IDW       = $clog2(NUM_CH);
  localparam int DEPTH     = 4096;
`ifdef ARB_MODE_FILTER_EN
  localparam bit FILTER = 1'b1;
`else
  localparam bit FILTER = 1'b0;
`endif

  typedef struct packed {
    logic [MW-1:0]  mode;
    logic [PVW-1:0] pv;
    logic [DW-1:0]  data;
  } beat_t;

  logic                  clk;
  logic                  rst;
  logic                  fifo_full;
  logic                  mstr0_cmplt;
  logic [NUM_CH-1:0]     slv_data_valid;
  logic [NUM_CH*MW-1:0]  slv_mode;
  logic [NUM_CH*PVW-1:0] slv_proc_valid;
  logic [NUM_CH*DW-1:0]  slv_data;
  logic [NUM_CH-1:0]     slv_ready;
  logic                  slvx_data_valid;
  logic [MW-1:0]         slvx_mode;
  logic [PVW-1:0]        slvx_proc_val;
  logic [DW-1:0]         slvx_data;
  logic [IDW-1:0]        slvx_grant_id;
  logic                  err_mode;

  arbiter_rr_n #(
    .NUM_CH(NUM_CH), .DW(DW), .MW(MW), .PVW(PVW), .MAX_BURST(MAX_BURST)
  ) dut (
    .clk(clk), .rst(rst), .fifo_full(fifo_full), .mstr0_cmplt(mstr0_cmplt),
    .slv_data_valid(slv_data_valid), .slv_mode(slv_mode),
    .slv_proc_valid(slv_proc_valid), .slv_data(slv_data),
    .slv_ready(slv_ready), .slvx_data_valid(slvx_data_valid),
    .slvx_mode(slvx_mode), .slvx_proc_val(slvx_proc_val),
    .slvx_data(slvx_data), .slvx_grant_id(slvx_grant_id),
    .err_mode(err_mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Slave beat lists
  beat_t mem [NUM_CH][DEPTH];
  int    head [NUM_CH];
  int    tail [NUM_CH];
  bit    present [NUM_CH];

  // Stimulus controls
  int p_valid, p_full, p_cmplt, full_start, full_len, cmplt_at;

  // Reference model state
  int    m_owner;   // -1 when no channel holds the grant
  int    m_ptr;
  int    m_beats;
  bit    m_ov;
  beat_t m_out;
  int    m_gid;
  bit    m_err;

  // Output log, one entry per sampled cycle (-1 = no beat)
  int         log_gid[$];
  logic [DW-1:0] log_data[$];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic push(input int ch, input logic [MW-1:0] mode,
                      input logic [PVW-1:0] pv, input logic [DW-1:0] data);
    if (tail[ch] < DEPTH) begin
      mem[ch][tail[ch]] = '{mode: mode, pv: pv, data: data};
      tail[ch]++;
    end
  endtask

  task automatic set_ctrl(input int pv, input int pf, input int pc,
                          input int fs, input int fl, input int ca);
    p_valid = pv; p_full = pf; p_cmplt = pc;
    full_start = fs; full_len = fl; cmplt_at = ca;
  endtask

  // One clock: check registered outputs, drive inputs, check ready, advance the model.
  task automatic cycle(input int c);
    logic [NUM_CH-1:0] er;
    int    n_owner, n_ptr, n_beats, g;
    bit    acc, fwd;
    beat_t b;

    check("out_valid", 64'(slvx_data_valid), 64'(m_ov));
    check("out_data",  64'(slvx_data),       64'(m_out.data));
    check("out_mode",  64'(slvx_mode),       64'(m_out.mode));
    check("out_pv",    64'(slvx_proc_val),   64'(m_out.pv));
    check("grant_id",  64'(slvx_grant_id),   64'(m_gid));
    check("err_mode",  64'(err_mode),        64'(m_err));
    log_gid.push_back(slvx_data_valid ? int'(slvx_grant_id) : -1);
    log_data.push_back(slvx_data);

    for (int i = 0; i < NUM_CH; i++) begin
      if (!present[i] && head[i] < tail[i] && $urandom_range(99) < p_valid)
        present[i] = 1'b1;
      slv_data_valid[i] = present[i];
      b = (head[i] < tail[i]) ? mem[i][head[i]] : '0;
      slv_mode[i*MW +: MW]        = b.mode;
      slv_proc_valid[i*PVW +: PVW] = b.pv;
      slv_data[i*DW +: DW]         = b.data;
    end
    fifo_full   = ((c >= full_start) && (c < full_start + full_len)) ||
                  ($urandom_range(99) < p_full);
    mstr0_cmplt = (c == cmplt_at) || ($urandom_range(99) < p_cmplt);
    #1;

    er = '0; acc = 1'b0; fwd = 1'b0; g = 0; b = '0;
    n_owner = m_owner; n_ptr = m_ptr; n_beats = m_beats;
    if (m_owner < 0) begin
      if (mstr0_cmplt) n_ptr = 0;
      else
        for (int k = 0; k < NUM_CH; k++)
          if (n_owner < 0 && slv_data_valid[(m_ptr + k) % NUM_CH])
            n_owner = (m_ptr + k) % NUM_CH;
    end else begin
      g     = m_owner;
      er[g] = !fifo_full && !mstr0_cmplt;
      acc   = slv_data_valid[g] && er[g];
      if (mstr0_cmplt) begin
        n_owner = -1; n_ptr = 0; n_beats = 0;
      end else if ((acc && m_beats + 1 == MAX_BURST) ||
                   (!acc && !slv_data_valid[g] && !fifo_full)) begin
        n_owner = -1; n_ptr = (g + 1) % NUM_CH; n_beats = 0;
      end else if (acc) begin
        n_beats = m_beats + 1;
      end
    end
    check("slv_ready", 64'(slv_ready), 64'(er));

    @(posedge clk);
    if (acc) begin
      b   = mem[g][head[g]];
      fwd = !(FILTER && b.mode == {MW{1'b1}});
      if (fwd) begin m_out = b; m_gid = g; end
      else m_err = 1'b1;
      head[g]++;
      present[g] = 1'b0;
    end
    m_ov = acc && fwd;
    m_owner = n_owner; m_ptr = n_ptr; m_beats = n_beats;
    @(negedge clk);
  endtask

  task automatic run(input int n);
    log_gid.delete();
    log_data.delete();
    for (int c = 0; c < n; c++) cycle(c);
  endtask

  // Asynchronous reset pulse entered on a falling edge; outputs must clear at once.
  task automatic do_reset();
    rst = 1'b1;
    fifo_full = 1'b0; mstr0_cmplt = 1'b0; slv_data_valid = '0;
    slv_mode = '0; slv_proc_valid = '0; slv_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin head[i] = 0; tail[i] = 0; present[i] = 1'b0; end
    #1;
    check("rst_valid", 64'(slvx_data_valid), 64'(0));
    check("rst_data",  64'(slvx_data),       64'(0));
    check("rst_mode",  64'(slvx_mode),       64'(0));
    check("rst_pv",    64'(slvx_proc_val),   64'(0));
    check("rst_gid",   64'(slvx_grant_id),   64'(0));
    check("rst_err",   64'(err_mode),        64'(0));
    check("rst_ready", 64'(slv_ready),       64'(0));
    @(negedge clk);
    rst = 1'b0;
    m_owner = -1; m_ptr = 0; m_beats = 0; m_ov = 1'b0; m_out = '0; m_gid = 0; m_err = 1'b0;
  endtask

  function automatic int first_valid();
    for (int k = 0; k < log_gid.size(); k++) if (log_gid[k] >= 0) return k;
    return -1;
  endfunction

  initial begin : main
    logic [DW-1:0] words [4];
    logic [DW-1:0] sent [10];
    int vids[$];
    logic [DW-1:0] vdat[$];
    int first, gaps;

    words[0] = 32'h2DAAD83D; words[1] = 32'hF9B550E1;
    words[2] = 32'hA87EAF30; words[3] = 32'h8F57C788;
    do_reset();

    // Single channel 0, four fixed words
    set_ctrl(100, 0, 0, 0, 0, -1);
    for (int k = 0; k < 4; k++) push(0, 2'b10, 8'hFF, words[k]);
    run(10);
    first = first_valid();
    check("single_first", 64'(first), 64'(2));
    if (first < 0) first = 0;
    for (int k = 0; k < 4; k++) begin
      check("single_gid",  64'(log_gid[first + k]),  64'(0));
      check("single_data", 64'(log_data[first + k]), 64'(words[k]));
    end

    // All channels valid continuously: strict rotation, MAX_BURST each
    do_reset();
    set_ctrl(100, 0, 0, 0, 0, -1);
    for (int i = 0; i < NUM_CH; i++)
      for (int k = 0; k < 40; k++) push(i, MW'($urandom_range(2)), PVW'($urandom), $urandom);
    run(80);
    vids.delete(); gaps = 0; first = -1;
    for (int k = 0; k < log_gid.size(); k++) begin
      if (log_gid[k] >= 0) begin
        if (first < 0) first = k;
        if (vids.size() < NUM_CH * MAX_BURST) vids.push_back(log_gid[k]);
      end else if (first >= 0 && vids.size() < NUM_CH * MAX_BURST) gaps++;
    end
    check("rot_first", 64'(first), 64'(2));
    check("rot_count", 64'(vids.size()), 64'(NUM_CH * MAX_BURST));
    for (int k = 0; k < vids.size(); k++)
      check("rot_gid", 64'(vids[k]), 64'((k / MAX_BURST) % NUM_CH));
    check("rot_gaps", 64'(gaps), 64'(NUM_CH - 1));

    // fifo_full for 5 cycles mid-burst on channel 2
    do_reset();
    set_ctrl(100, 0, 0, 4, 5, -1);
    for (int k = 0; k < 10; k++) begin
      sent[k] = $urandom;
      push(2, 2'b01, 8'h3C, sent[k]);
    end
    run(25);
    vids.delete(); vdat.delete();
    for (int k = 0; k < log_gid.size(); k++)
      if (log_gid[k] >= 0) begin vids.push_back(log_gid[k]); vdat.push_back(log_data[k]); end
    check("stall_count", 64'(vids.size()), 64'(10));
    for (int k = 0; k < vids.size() && k < 10; k++) begin
      check("stall_gid",  64'(vids[k]), 64'(2));
      check("stall_data", 64'(vdat[k]), 64'(sent[k]));
    end

    // Completion pulse during a channel 3 burst, channels 1 and 3 pending
    do_reset();
    set_ctrl(100, 0, 0, 0, 0, -1);
    push(2, 2'b00, 8'h01, 32'h0000_0002);
    run(4);
    for (int k = 0; k < 8; k++) begin
      push(1, 2'b00, 8'h11, 32'h1000_0000 + k);
      push(3, 2'b00, 8'h33, 32'h3000_0000 + k);
    end
    set_ctrl(100, 0, 0, 0, 0, 4);
    run(20);
    vids.delete();
    for (int k = 0; k < log_gid.size(); k++) if (log_gid[k] >= 0) vids.push_back(log_gid[k]);
    check("cmplt_count", 64'(vids.size() >= 4), 64'(1));
    for (int k = 0; k < 4 && k < vids.size(); k++)
      check("cmplt_gid", 64'(vids[k]), 64'((k < 3) ? 3 : 1));

    // Reset mid-burst, then the first grant must be channel 0
    do_reset();
    set_ctrl(100, 0, 0, 0, 0, -1);
    for (int i = 0; i < NUM_CH; i++)
      for (int k = 0; k < 20; k++) push(i, 2'b00, 8'h5A, $urandom);
    run(8);
    check("mid_burst_valid", 64'(slvx_data_valid), 64'(1));
    do_reset();
    for (int i = 0; i < NUM_CH; i++)
      for (int k = 0; k < 4; k++) push(i, 2'b00, 8'hA5, $urandom);
    run(6);
    first = first_valid();
    check("post_rst_first", 64'(first), 64'(2));
    if (first < 0) first = 0;
    check("post_rst_gid", 64'(log_gid[first]), 64'(0));

    // Reserved-mode beat on channel 1
    do_reset();
    set_ctrl(100, 0, 0, 0, 0, -1);
    push(1, 2'b11, 8'h0F, 32'hDEADBEEF);
    run(8);
    first = first_valid();
`ifdef ARB_MODE_FILTER_EN
    check("filt_forwarded", 64'(first), 64'(-1));
    check("filt_err", 64'(err_mode), 64'(1));
`else
    check("filt_forwarded", 64'(first), 64'(2));
    if (first < 0) first = 0;
    check("filt_data", 64'(log_data[first]), 64'(32'hDEADBEEF));
    check("filt_err", 64'(err_mode), 64'(0));
`endif

    // Randomized traffic with backpressure and completion pulses
    do_reset();
    set_ctrl(60, 25, 2, 0, 0, -1);
    for (int i = 0; i < NUM_CH; i++)
      for (int k = 0; k < 600; k++) push(i, MW'($urandom), PVW'($urandom), $urandom);
    run(2000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/arbiter_rr_n.md
Name: arbiter_rr_n

Overview:
- N-channel round-robin successor to the two-slave pixel arbiter.
- Merges NUM_CH slave streams (mode, proc-valid mask, data) into one registered master stream that feeds the downstream FIFO.
- Holds a grant across bursts of up to MAX_BURST beats and honours FIFO backpressure.
- Releases and re-homes the grant on master completion.

Parameters:
- NUM_CH, 4, number of slave channels (2..8)
- DW, 32, data width per beat
- MW, 2, mode field width
- PVW, 8, proc-valid mask width
- MAX_BURST, 16, maximum beats per grant before forced re-arbitration (1..255)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset; one clock; reset is asynchronous and active-high
- fifo_full  in  1  downstream FIFO full; guarantees one entry of slack
- mstr0_cmplt  in  1  master frame complete, single-cycle pulse
- slv_data_valid  in  NUM_CH  per-channel beat valid
- slv_mode  in  NUM_CH*MW  per-channel mode, channel i at [i*MW +: MW]
- slv_proc_valid  in  NUM_CH*PVW  per-channel proc-valid mask
- slv_data  in  NUM_CH*DW  per-channel data
- slv_ready  out  NUM_CH  per-channel accept (combinational)
- slvx_data_valid  out  1  registered output beat strobe
- slvx_mode  out  MW  registered mode
- slvx_proc_val  out  PVW  registered proc-valid mask
- slvx_data  out  DW  registered data
- slvx_grant_id  out  $clog2(NUM_CH)  channel that sourced the current output beat
- err_mode  out  1  sticky reserved-mode flag (see Optional Feature)

Behaviour:
- Reset values: all outputs 0; state=IDLE; rr_ptr=0; burst_cnt=0; grant=none.
- States: IDLE, GRANT.
- IDLE:
  - slv_ready=0.
  - If any slv_data_valid: grant the first valid channel scanning rr_ptr, rr_ptr+1, … (mod NUM_CH); go to GRANT.
  - Arbitration costs exactly one cycle.
- GRANT:
  - slv_ready[g] = ~fifo_full & ~mstr0_cmplt; all other ready bits 0.
  - Beat accepted when slv_data_valid[g] & slv_ready[g]. On accept, the next cycle has slvx_data_valid=1 with that channel's fields and slvx_grant_id=g (latency 1).
  - When no beat is accepted, the next cycle has slvx_data_valid=0; the other output fields hold their last values.
  - burst_cnt increments per accepted beat.
- Leave GRANT for IDLE when any of:
  - slv_data_valid[g]=0 while fifo_full=0;
  - the accepted beat makes burst_cnt reach MAX_BURST;
  - mstr0_cmplt=1.
- On leaving GRANT:
  - rr_ptr = (g+1) mod NUM_CH;
  - burst_cnt=0.
- mstr0_cmplt:
  - Takes precedence over all other exit conditions.
  - No beat is accepted in that cycle.
  - rr_ptr forced to 0.
  - In IDLE it also suppresses arbitration for that cycle.
- fifo_full in GRANT:
  - Stalls without losing the grant.
  - burst_cnt frozen.
  - A valid drop during a stall does not release the grant.
- Simultaneous valid on all channels: strict rotation 0,1,…,NUM_CH-1 with MAX_BURST beats each.
- Reset mid-burst: immediate return to reset values; any in-flight beat is discarded.
- Slaves must hold data stable while valid=1 and ready=0.

Optional Feature:
- Macro: ARB_MODE_FILTER_EN.
- Defined:
  - An accepted beat with mode = all-ones (reserved) is consumed (ready high, counts toward burst) but not forwarded; slvx_data_valid stays 0.
  - err_mode sets to 1 and stays set until rst.
- Undefined: reserved-mode beats are forwarded normally; err_mode tied 0.

Test Plan:
- Single channel 0, mode=2'b10, proc_valid=8'hFF, 4 beats 32'h2DAAD83D, 32'hF9B550E1, 32'hA87EAF30, 32'h8F57C788 -> same 4 words on slvx_data in order, grant_id=0, first beat 2 cycles after valid (1 arb + 1 reg).
- All 4 channels valid continuously, MAX_BURST=16 -> output grant_id sequence 0×16,1×16,2×16,3×16,0…; exactly one idle output cycle between bursts.
- fifo_full asserted 5 cycles mid-burst on channel 2 -> slv_ready=0 for those 5 cycles; no beats dropped or duplicated; grant stays on 2; burst_cnt resumes.
- mstr0_cmplt pulse during channel 3 burst with channels 1,3 valid -> no accept that cycle; next grant goes to channel 1 (rr_ptr=0 scan).
- Assert rst for one cycle mid-burst -> all outputs 0 asynchronously; after release, first grant goes to channel 0.
- ARB_MODE_FILTER_EN: channel 1 sends mode=2'b11 beat 32'hDEADBEEF -> not on output, err_mode=1 held. Without the macro: beat forwarded, err_mode=0.
